// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the core's packed two-channel request side plus the
// single memory-controller port. slave = arbiter view, master = core/memory view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [3:0]          rw_flag;
   logic [2*ADDR_W-1:0] addr;
   logic [2*DATA_W-1:0] write_data;
   logic [7:0]          write_mask;
   logic [2*DATA_W-1:0] read_data;
   logic [1:0]          busy;
   logic [1:0]          done;

   logic [1:0]          mem_rw_flag;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_write_data;
   logic [3:0]          mem_write_mask;
   logic [DATA_W-1:0]   mem_read_data;
   logic                mem_busy;
   logic                mem_done;

   modport slave (
      input  rw_flag, addr, write_data, write_mask,
      input  mem_read_data, mem_busy, mem_done,
      output read_data, busy, done,
      output mem_rw_flag, mem_addr, mem_write_data, mem_write_mask
   );

   modport master (
      output rw_flag, addr, write_data, write_mask,
      output mem_read_data, mem_busy, mem_done,
      input  read_data, busy, done,
      input  mem_rw_flag, mem_addr, mem_write_data, mem_write_mask
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-channel (ch0 DCACHE, ch1 ICACHE) to single memory port arbiter, one transaction
// at a time. Define MEM_ARB_DPRIO_EN for fixed ch0 priority instead of round-robin.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t state;
   logic   last_grant;
   logic   grant;
   logic   is_read;

   logic [1:0]        cand;
   logic              pick;
   logic [1:0]        raw_flag;
   logic [1:0]        pick_flag;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_data;
   logic [3:0]        pick_mask;

   // NOTE: every signal gets a default at the top so no path through the block leaves it unassigned (no latch).
   always_comb begin
      pick      = 1'b0;
      cand[0]   = (bus.rw_flag[1:0] != 2'b00) && !bus.done[0];
      cand[1]   = (bus.rw_flag[3:2] != 2'b00) && !bus.done[1];
      case (cand)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
`ifdef MEM_ARB_DPRIO_EN
         2'b11:   pick = 1'b0;
`else
         2'b11:   pick = ~last_grant;
`endif
         default: pick = 1'b0;
      endcase

      raw_flag  = pick ? bus.rw_flag[3:2] : bus.rw_flag[1:0];
      // Read+write together is served as a plain write.
      pick_flag = raw_flag[1] ? 2'b10 : raw_flag;
      pick_addr = pick ? bus.addr[2*ADDR_W-1:ADDR_W]       : bus.addr[ADDR_W-1:0];
      pick_data = pick ? bus.write_data[2*DATA_W-1:DATA_W] : bus.write_data[DATA_W-1:0];
      pick_mask = pick ? bus.write_mask[7:4]               : bus.write_mask[3:0];
   end

   // NOTE: non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state              <= ST_IDLE;
         last_grant         <= 1'b1;
         grant              <= 1'b0;
         is_read            <= 1'b0;
         bus.mem_rw_flag    <= '0;
         bus.mem_addr       <= '0;
         bus.mem_write_data <= '0;
         bus.mem_write_mask <= '0;
         bus.busy           <= '0;
         bus.done           <= '0;
         bus.read_data      <= '0;
      end else begin
         bus.done <= '0;
         case (state)
            ST_IDLE: begin
               if (cand != 2'b00) begin
                  grant              <= pick;
                  last_grant         <= pick;
                  is_read            <= (pick_flag == 2'b01);
                  bus.mem_rw_flag    <= pick_flag;
                  bus.mem_addr       <= pick_addr;
                  bus.mem_write_data <= pick_data;
                  bus.mem_write_mask <= pick_mask;
                  bus.busy           <= 2'b11;
                  state              <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               // Address, data and mask stay put after acceptance; only the strobe drops.
               if (!bus.mem_busy) begin
                  bus.mem_rw_flag <= '0;
                  state           <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (bus.mem_done) begin
                  if (is_read) begin
                     if (grant) bus.read_data[2*DATA_W-1:DATA_W] <= bus.mem_read_data;
                     else       bus.read_data[DATA_W-1:0]        <= bus.mem_read_data;
                  end
                  bus.done <= grant ? 2'b10 : 2'b01;
                  bus.busy <= '0;
                  state    <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vector table for single-channel read/write
// transactions, plus hand sequences for round-robin, done-cycle re-request and async reset.
module tb_mem_arbiter;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  rw;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic        mbusy;
      logic        mdone;
      logic [31:0] mrdata;
      logic [1:0]  e_mrw;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic [3:0]  e_mmask;
      logic [1:0]  e_busy;
      logic [1:0]  e_done;
      logic [63:0] e_rd;
   } vec_t;

   localparam int NV = 14;
   vec_t vec [NV];

   logic [63:0] exp_rd;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_req(input string name);
      int t;
      t = 0;
      while (bus.mem_rw_flag == 2'b00 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({name, " request issued"}, 64'(bus.mem_rw_flag != 2'b00), 64'd1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, " mem_rw_flag"},    64'(bus.mem_rw_flag),    64'd0);
      check({name, " mem_addr"},       64'(bus.mem_addr),       64'd0);
      check({name, " mem_write_data"}, 64'(bus.mem_write_data), 64'd0);
      check({name, " mem_write_mask"}, 64'(bus.mem_write_mask), 64'd0);
      check({name, " busy"},           64'(bus.busy),           64'd0);
      check({name, " done"},           64'(bus.done),           64'd0);
      check({name, " read_data"},      bus.read_data,           64'd0);
   endtask

   initial begin
      // Test 1: ch0 read of 0x100, memory answers one idle cycle after acceptance.
      vec[0]  = '{4'b0001, 64'h100, 64'h0, 8'h00, 1'b0, 1'b0, 32'h0,
                  2'b01, 32'h100, 32'h0, 4'h0, 2'b11, 2'b00, 64'h0};
      vec[1]  = '{4'b0001, 64'h100, 64'h0, 8'h00, 1'b0, 1'b0, 32'h0,
                  2'b00, 32'h100, 32'h0, 4'h0, 2'b11, 2'b00, 64'h0};
      vec[2]  = '{4'b0001, 64'h100, 64'h0, 8'h00, 1'b0, 1'b0, 32'h0,
                  2'b00, 32'h100, 32'h0, 4'h0, 2'b11, 2'b00, 64'h0};
      vec[3]  = '{4'b0001, 64'h100, 64'h0, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF,
                  2'b00, 32'h100, 32'h0, 4'h0, 2'b00, 2'b01, 64'h0000_0000_DEAD_BEEF};
      vec[4]  = '{4'b0000, 64'h100, 64'h0, 8'h00, 1'b0, 1'b0, 32'h0,
                  2'b00, 32'h100, 32'h0, 4'h0, 2'b00, 2'b00, 64'h0000_0000_DEAD_BEEF};
      vec[5]  = '{4'b0000, 64'h100, 64'h0, 8'h00, 1'b0, 1'b0, 32'h0,
                  2'b00, 32'h100, 32'h0, 4'h0, 2'b00, 2'b00, 64'h0000_0000_DEAD_BEEF};
      // Test 3: ch1 rw=11 write, memory busy for the first 4 issue cycles.
      vec[6]  = '{4'b1100, 64'h0000_0200_0000_0000, 64'h1234_5678_0000_0000, 8'h50, 1'b1, 1'b0, 32'h0,
                  2'b10, 32'h200, 32'h12345678, 4'h5, 2'b11, 2'b00, 64'h0000_0000_DEAD_BEEF};
      for (int i = 7; i <= 10; i++) vec[i] = vec[6];
      vec[11] = '{4'b1100, 64'h0000_0200_0000_0000, 64'h1234_5678_0000_0000, 8'h50, 1'b0, 1'b0, 32'h0,
                  2'b00, 32'h200, 32'h12345678, 4'h5, 2'b11, 2'b00, 64'h0000_0000_DEAD_BEEF};
      vec[12] = '{4'b1100, 64'h0000_0200_0000_0000, 64'h1234_5678_0000_0000, 8'h50, 1'b0, 1'b1, 32'hFFFFFFFF,
                  2'b00, 32'h200, 32'h12345678, 4'h5, 2'b00, 2'b10, 64'h0000_0000_DEAD_BEEF};
      vec[13] = '{4'b0000, 64'h0000_0200_0000_0000, 64'h1234_5678_0000_0000, 8'h50, 1'b0, 1'b0, 32'h0,
                  2'b00, 32'h200, 32'h12345678, 4'h5, 2'b00, 2'b00, 64'h0000_0000_DEAD_BEEF};

      rst_n              = 1'b0;
      bus.rw_flag        = '0;
      bus.addr           = '0;
      bus.write_data     = '0;
      bus.write_mask     = '0;
      bus.mem_read_data  = '0;
      bus.mem_busy       = 1'b0;
      bus.mem_done       = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         bus.rw_flag       = vec[i].rw;
         bus.addr          = vec[i].addr;
         bus.write_data    = vec[i].wdata;
         bus.write_mask    = vec[i].wmask;
         bus.mem_busy      = vec[i].mbusy;
         bus.mem_done      = vec[i].mdone;
         bus.mem_read_data = vec[i].mrdata;
         @(negedge clk);
         check($sformatf("v%0d mem_rw_flag", i),    64'(bus.mem_rw_flag),    64'(vec[i].e_mrw));
         check($sformatf("v%0d mem_addr", i),       64'(bus.mem_addr),       64'(vec[i].e_maddr));
         check($sformatf("v%0d mem_write_data", i), 64'(bus.mem_write_data), 64'(vec[i].e_mwdata));
         check($sformatf("v%0d mem_write_mask", i), 64'(bus.mem_write_mask), 64'(vec[i].e_mmask));
         check($sformatf("v%0d busy", i),           64'(bus.busy),           64'(vec[i].e_busy));
         check($sformatf("v%0d done", i),           64'(bus.done),           64'(vec[i].e_done));
         check($sformatf("v%0d read_data", i),      bus.read_data,           vec[i].e_rd);
      end
      exp_rd = 64'h0000_0000_DEAD_BEEF;
      bus.mem_done   = 1'b0;
      bus.write_data = '0;
      bus.write_mask = '0;

      // Test 2: both channels read continuously; grants must alternate starting with ch0.
      bus.rw_flag = 4'b0101;
      bus.addr    = {32'h20, 32'h10};
      for (int k = 0; k < 6; k++) begin
         logic ch;
         ch = k[0];
         wait_req($sformatf("rr%0d", k));
         check($sformatf("rr%0d mem_addr", k), 64'(bus.mem_addr), ch ? 64'h20 : 64'h10);
         check($sformatf("rr%0d mem_rw_flag", k), 64'(bus.mem_rw_flag), 64'd1);
         @(negedge clk);
         bus.mem_done      = 1'b1;
         bus.mem_read_data = 32'hA5A5_0000 + 32'(k);
         @(negedge clk);
         bus.mem_done = 1'b0;
         if (ch) exp_rd[63:32] = 32'hA5A5_0000 + 32'(k);
         else    exp_rd[31:0]  = 32'hA5A5_0000 + 32'(k);
         check($sformatf("rr%0d done", k), 64'(bus.done), ch ? 64'd2 : 64'd1);
         check($sformatf("rr%0d read_data", k), bus.read_data, exp_rd);
      end
      bus.rw_flag = '0;
      repeat (2) @(negedge clk);

      // Test 4: ch0 holds its request through done, then reissues with a new address.
      bus.rw_flag = 4'b0001;
      bus.addr    = 64'h300;
      wait_req("rereq first");
      check("rereq first mem_addr", 64'(bus.mem_addr), 64'h300);
      @(negedge clk);
      bus.mem_done      = 1'b1;
      bus.mem_read_data = 32'h1111_2222;
      @(negedge clk);
      bus.mem_done = 1'b0;
      exp_rd[31:0] = 32'h1111_2222;
      check("rereq first done", 64'(bus.done), 64'd1);
      bus.addr = 64'h340;
      @(negedge clk);
      check("rereq no duplicate grant", 64'(bus.mem_rw_flag), 64'd0);
      check("rereq idle busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("rereq second mem_rw_flag", 64'(bus.mem_rw_flag), 64'd1);
      check("rereq second mem_addr", 64'(bus.mem_addr), 64'h340);
      @(negedge clk);
      bus.mem_done      = 1'b1;
      bus.mem_read_data = 32'h3333_4444;
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.rw_flag  = '0;
      exp_rd[31:0] = 32'h3333_4444;
      check("rereq second done", 64'(bus.done), 64'd1);
      check("rereq second read_data", bus.read_data, exp_rd);
      @(negedge clk);

      // Test 5: reset while waiting on memory; a late mem_done must be ignored.
      bus.rw_flag = 4'b0100;
      bus.addr    = 64'h0000_0500_0000_0000;
      wait_req("rst");
      @(negedge clk);
      check("rst wait busy", 64'(bus.busy), 64'd3);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async reset");
      bus.rw_flag = '0;
      @(negedge clk);
      rst_n             = 1'b1;
      bus.mem_done      = 1'b1;
      bus.mem_read_data = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.mem_done = 1'b0;
      check("late mem_done done", 64'(bus.done), 64'd0);
      check("late mem_done read_data", bus.read_data, 64'd0);
      @(negedge clk);
      check("late mem_done next done", 64'(bus.done), 64'd0);
      check("late mem_done busy", 64'(bus.busy), 64'd0);

      // First tie after reset goes to ch0.
      bus.rw_flag = 4'b0101;
      bus.addr    = {32'h620, 32'h610};
      wait_req("tie");
      check("tie after reset mem_addr", 64'(bus.mem_addr), 64'h610);
      @(negedge clk);
      bus.mem_done      = 1'b1;
      bus.mem_read_data = 32'h0BAD_F00D;
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.rw_flag  = '0;
      check("tie after reset done", 64'(bus.done), 64'd1);
      check("tie after reset read_data", bus.read_data, 64'h0000_0000_0BAD_F00D);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port between the two cache channels of the CPU core.
- Channel 0 is DCACHE, on the low slice. Channel 1 is ICACHE, on the high slice.
- Sits between the core's packed 2-channel memory interface and the single-port memory controller.
- Serialises requests one at a time, with round-robin grant, and returns per-channel busy, done and read data.

Parameters:
ADDR_W, 32, address width per channel
DATA_W, 32, data width per channel

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset; asynchronous, active-low
rw_flag  input  4  per channel, 2 bits each: bit0 = read, bit1 = write; channel i occupies [2i+1:2i]
addr  input  2*ADDR_W  per-channel address
write_data  input  2*DATA_W  per-channel write data
write_mask  input  8  per-channel byte mask, 4 bits each
read_data  output  2*DATA_W  per-channel read data, registered
busy  output  2  per-channel busy
done  output  2  per-channel completion pulse
mem_rw_flag  output  2  to memory: bit0 = read, bit1 = write
mem_addr  output  ADDR_W  to memory
mem_write_data  output  DATA_W  to memory
mem_write_mask  output  4  to memory
mem_read_data  input  DATA_W  from memory
mem_busy  input  1  memory cannot accept a request
mem_done  input  1  memory completion pulse, with mem_read_data valid in the same cycle

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, last_grant=1, grant=0.
  - All outputs 0: mem_rw_flag, mem_addr, mem_write_data, mem_write_mask, busy, done, read_data.
  - Any transaction in flight is abandoned.
  - Requester contract: hold rw_flag/addr/data/mask stable from the cycle rw_flag!=0 until done[i] is seen.
- Channel i requests when its rw_flag!=0.
  - rw_flag=2'b11 is treated as a write; the latched flag becomes 2'b10.
- busy[i]=1 whenever state!=IDLE, for both channels. busy is 0 in IDLE.
- State machine:
  - IDLE:
    - Candidates are channels with rw_flag!=0 AND done[i]==0. The done[i] exclusion prevents re-granting a request whose done is still visible.
    - One candidate: grant it.
    - Both candidates: grant the channel != last_grant.
    - On grant, latch flag/addr/data/mask/grant, set last_grant=grant, go to ISSUE.
    - mem_done is ignored in IDLE.
  - ISSUE:
    - Drive mem_rw_flag and the other mem_* outputs from the latched copy.
    - mem_busy==0 at the clock edge: request accepted; mem_rw_flag<=0 and go to WAIT. mem_addr, mem_write_data and mem_write_mask hold their value.
    - mem_busy==1: stay in ISSUE, outputs held.
  - WAIT:
    - On mem_done: if the latched flag was a read, read_data[grant slice]<=mem_read_data. Writes leave read_data unchanged.
    - Also set done[grant]<=1 and go to IDLE.
- done is a single-cycle pulse, cleared the next cycle. It is never asserted on both channels in the same cycle.
- Each read_data slice holds its value until the next read completes on that channel.
- Timing from request first visible in IDLE at cycle N, with mem_busy=0:
  - mem_rw_flag high during cycle N+1.
  - Earliest mem_done in cycle N+2.
  - done[i] in cycle N+3.
- The first tie after reset goes to channel 0.

Optional Feature:
- Macro: MEM_ARB_DPRIO_EN.
- Defined: fixed priority. On a tie in IDLE, channel 0 (DCACHE) always wins; last_grant is unused.
- Undefined: round-robin as described above.

Test Plan:
1. Reset released; ch0 read, addr=0x100; memory returns 0xDEADBEEF two cycles after acceptance.
   - Expect: mem_rw_flag=01 for 1 cycle, mem_addr=0x100, read_data[31:0]=0xDEADBEEF, done=2'b01 for exactly 1 cycle, busy=2'b11 from N+1 until done.
2. Both channels request reads in the same cycle, held across completions (ch0 addr 0x10, ch1 addr 0x20), repeated 3 times.
   - Default build: grant order ch0, ch1, ch0, ch1.
   - MEM_ARB_DPRIO_EN build: ch0 always wins the tie; ch1 is served only after ch0 drops its request.
3. ch1 write with rw_flag=11, write_data=0x12345678, write_mask=0x5; mem_busy held high 4 cycles.
   - Expect: mem_rw_flag=10 stable for 5 cycles, mask 0x5 and data stable throughout; done=2'b10; read_data unchanged.
4. ch0 keeps rw_flag asserted during its done cycle, then changes addr and issues a new read.
   - Expect: no duplicate grant in the done cycle; second request served with the new addr.
5. RST pulsed low while in WAIT; then mem_done arrives after reset release.
   - Expect: all outputs 0 immediately (async); the late mem_done produces no done pulse.
